// File: rtl/stack_ctrl_if.sv
// Request/response handshake between the control unit (master) and the
// stack sequencer (slave).
interface stack_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err_overflow;
  logic        err_underflow;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_data, err_overflow, err_underflow
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_data, err_overflow, err_underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: runs one PUSH/POP/PEEK at a time, ordering memory strobes
// and SP inc/dec, and rejects overflow/underflow without touching SP or memory.
module stack_ctrl #(
  parameter logic [15:0] SP_TOP    = 16'h01FF,
  parameter logic [15:0] SP_BOTTOM = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  stack_ctrl_if.slave bus,
  input  logic [15:0] sp_in,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] mem_addr,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        empty,
  output logic        full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic [15:0] rdata_q, rdata_d;
  logic        accept_s;

  assign empty    = (sp_in == SP_TOP);
  assign full     = (sp_in < SP_BOTTOM);
  assign accept_s = (state_q == IDLE) && bus.req_valid;

  // State and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      data_q  <= 16'h0000;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; empty/full are judged only at acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d   = bus.req_op;
          data_d = bus.req_data;
          ovf_d  = 1'b0;
          udf_d  = 1'b0;
          case (bus.req_op)
            OP_NOP: begin
              state_d = ACK;
            end
            OP_PUSH: begin
              if (full) begin
                ovf_d   = 1'b1;
                state_d = ACK;
              end else begin
                state_d = WRITE;
              end
            end
            default: begin
              if (empty) begin
                udf_d   = 1'b1;
                state_d = ACK;
              end else begin
                state_d = READ;
              end
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        rdata_d = 16'h0000;
        state_d = IDLE;
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        rdata_d = mem_rdata;
        state_d = IDLE;
      end
      ACK: begin
        rdata_d = 16'h0000;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded strobes; rsp_data holds the last result between responses.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_data      = rdata_q;
    bus.err_overflow  = 1'b0;
    bus.err_underflow = 1'b0;
    sp_inc            = 1'b0;
    sp_dec            = 1'b0;
    mem_addr          = 16'h0000;
    mem_wr            = 1'b0;
    mem_rd            = 1'b0;
    mem_wdata         = 16'h0000;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      WRITE: begin
        mem_wr        = 1'b1;
        mem_addr      = sp_in;
        mem_wdata     = data_q;
        sp_dec        = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 16'h0000;
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = sp_in + 16'd1;
      end
      WAIT: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_rdata;
        sp_inc        = (op_q == OP_POP);
      end
      ACK: begin
        bus.rsp_valid     = 1'b1;
        bus.rsp_data      = 16'h0000;
        bus.err_overflow  = ovf_q;
        bus.err_underflow = udf_q;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

endmodule
